// File: rtl/lbp_pkg.sv
// Shared constants and state encoding for the LBP histogram block.
// Imported by lbp_hist and lbp_hist_ram.
package lbp_pkg;

  localparam int IMG_W = 128;
  localparam int NBINS = 256;
  localparam int CNT_W = 14;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DUMP,
    DONE
  } state_t;

endpackage

// File: rtl/lbp_hist_ram.sv
// 256 x CNT_W histogram storage.
// One write port and a registered (1-cycle) read port.
module lbp_hist_ram
  import lbp_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [7:0]       raddr,
  output logic [CNT_W-1:0] rdata
);

  logic [CNT_W-1:0] mem [NBINS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulate one frame, then stream the 256 bins out.
// Touched flags make reset instant; untouched bins read back as zero.
module lbp_hist
  import lbp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic             hist_done,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [6:0] EDGE = 7'(IMG_W - 1);

  state_t state, state_nx;

  logic             drain_cnt;
  logic [NBINS-1:0] touched;
  logic             p_valid;
  logic [7:0]       p_bin;
  logic             w_valid;
  logic [7:0]       w_bin;
  logic [CNT_W-1:0] w_data;
  logic [CNT_W-1:0] rdata;
  logic [CNT_W-1:0] old_val;
  logic [CNT_W-1:0] new_val;
  logic [7:0]       raddr;
  logic [6:0]       row;
  logic [6:0]       col;
  logic             interior;
  logic             accept;
  logic             drop;
  logic             hs;

  assign row = lbp_addr[13:7];
  assign col = lbp_addr[6:0];

  assign interior = (row != 7'd0) && (row != EDGE) &&
                    (col != 7'd0) && (col != EDGE);

  assign accept = lbp_valid && (state == ACCUM) && interior;
  assign drop   = lbp_valid && !accept;
  assign hs     = hist_valid && hist_ready;

  // The write issued last cycle is not yet visible in the read data.
  always_comb begin
    old_val = '0;
    if (w_valid && (w_bin == p_bin))
      old_val = w_data;
    else if (touched[p_bin])
      old_val = rdata;
  end

  assign new_val = (&old_val) ? old_val : old_val + CNT_W'(1);

  always_comb begin
    raddr = lbp_data;
    if (state == DUMP)
      raddr = hs ? hist_bin + 8'd1 : hist_bin;
  end

  assign hist_count =
    (hist_valid && touched[hist_bin]) ? rdata : '0;

  lbp_hist_ram u_ram (
    .clk   (clk),
    .we    (p_valid),
    .waddr (p_bin),
    .wdata (new_val),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (finish) state_nx = DRAIN;
      DRAIN: if (drain_cnt) state_nx = DUMP;
      DUMP:  if (hs && (hist_bin == 8'hFF)) state_nx = DONE;
      DONE:  state_nx = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt  <= 1'b0;
      touched    <= '0;
      p_valid    <= 1'b0;
      p_bin      <= '0;
      w_valid    <= 1'b0;
      w_bin      <= '0;
      w_data     <= '0;
      hist_valid <= 1'b0;
      hist_bin   <= '0;
      hist_done  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      p_valid   <= accept;
      p_bin     <= lbp_data;
      w_valid   <= p_valid;
      w_bin     <= p_bin;
      w_data    <= new_val;
      if (p_valid)
        touched[p_bin] <= 1'b1;
      if (drop && !(&drop_cnt))
        drop_cnt <= drop_cnt + CNT_W'(1);
      if (state == DUMP) begin
        if (!hist_valid) begin
          hist_valid <= 1'b1;
        end else if (hs) begin
          if (hist_bin == 8'hFF) hist_valid <= 1'b0;
          else                   hist_bin   <= hist_bin + 8'd1;
        end
      end
      hist_done <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist with a bin-order scoreboard.
// Expected bins are queued at finish and popped on each handshake.
module tb_lbp_hist;
  import lbp_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lbp_valid = 1'b0;
  logic [13:0]      lbp_addr = '0;
  logic [7:0]       lbp_data = '0;
  logic             finish = 1'b0;
  logic             hist_ready = 1'b0;
  logic             hist_valid;
  logic             hist_done;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic [CNT_W-1:0] drop_cnt;

  typedef struct packed {
    logic [7:0]       bin;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   model[NBINS];
  int   mdrop;
  bit   acc;
  int   total;
  int   bad;
  int   got;
  int   sum;

  always #5 clk = ~clk;

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_done  (hist_done),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < NBINS; b++) model[b] = 0;
    mdrop = 0;
    acc = 1'b1;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    lbp_valid = 1'b0;
    finish = 1'b0;
    hist_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic send(input int a, input int d);
    int r;
    int c;
    @(negedge clk);
    lbp_valid = 1'b1;
    lbp_addr = 14'(a);
    lbp_data = 8'(d);
    r = a / IMG_W;
    c = a % IMG_W;
    if (acc && r >= 1 && r <= 126 && c >= 1 && c <= 126) begin
      if (model[d] < 16383) model[d]++;
    end else begin
      mdrop++;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    lbp_valid = 1'b0;
  endtask

  task automatic start_dump();
    exp_t e;
    @(negedge clk);
    finish = 1'b1;
    acc = 1'b0;
    for (int b = 0; b < NBINS; b++) begin
      e.bin = 8'(b);
      e.cnt = CNT_W'(model[b]);
      sb.push_back(e);
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
  task automatic run_dump(input int mode, input int stop_at);
    exp_t e;
    bit stalled;
    logic [7:0] pb;
    logic [CNT_W-1:0] pc;
    int n;
    got = 0;
    sum = 0;
    stalled = 1'b0;
    pb = '0;
    pc = '0;
    n = 0;
    while (sb.size() > 0 && n < 3000 && got < stop_at) begin
      @(negedge clk);
      hist_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      n++;
      if (stalled) begin
        chk("stall_valid", 32'(hist_valid), 32'd1);
        chk("stall_bin", 32'(hist_bin), 32'(pb));
        chk("stall_count", 32'(hist_count), 32'(pc));
      end
      stalled = hist_valid && !hist_ready;
      pb = hist_bin;
      pc = hist_count;
      if (hist_valid && hist_ready) begin
        e = sb.pop_front();
        chk("bin_order", 32'(hist_bin), 32'(e.bin));
        chk("bin_count", 32'(hist_count), 32'(e.cnt));
        got++;
        sum += int'(hist_count);
      end
    end
    if (got < stop_at && sb.size() > 0) begin
      total++;
      bad++;
      $error("FAIL dump_timeout observed=%0d expected=%0d", got, 256);
    end
  endtask

  task automatic end_check();
    @(negedge clk);
    chk("done", 32'(hist_done), 32'd1);
    chk("valid_after_done", 32'(hist_valid), 32'd0);
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
  endtask

  initial begin
    total = 0;
    bad = 0;
    clear_model();

    // reset state
    do_reset();
    chk("rst_valid", 32'(hist_valid), 32'd0);
    chk("rst_bin", 32'(hist_bin), 32'd0);
    chk("rst_count", 32'(hist_count), 32'd0);
    chk("rst_done", 32'(hist_done), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // empty frame dumps 256 zeros
    start_dump();
    run_dump(0, 1000);
    chk("empty_handshakes", 32'(got), 32'd256);
    end_check();

    // back-to-back strobes to one bin
    do_reset();
    send(129, 5);
    send(130, 5);
    send(131, 5);
    idle();
    start_dump();
    run_dump(0, 1000);
    chk("fwd_sum", 32'(sum), 32'd3);
    end_check();

    // border drops, stalled dump, late strobe dropped
    do_reset();
    send(0, 7);
    send(127, 7);
    send(16256, 7);
    send(16383, 7);
    send(200, 7);
    idle();
    start_dump();
    run_dump(1, 1000);
    chk("border_got", 32'(got), 32'd256);
    end_check();
    send(300, 7);
    idle();
    chk("late_drop", 32'(drop_cnt), 32'(mdrop));

    // full interior frame
    do_reset();
    for (int r = 1; r <= 126; r++)
      for (int c = 1; c <= 126; c++)
        send(r * IMG_W + c, (r * IMG_W + c) % 256);
    idle();
    start_dump();
    run_dump(0, 1000);
    chk("frame_sum", 32'(sum), 32'd15876);
    end_check();

    // reset in the middle of a dump
    do_reset();
    send(200, 9);
    send(300, 9);
    idle();
    start_dump();
    run_dump(0, 100);
    @(negedge clk);
    chk("abort_valid_pre", 32'(hist_valid), 32'd1);
    chk("abort_bin_pre", 32'(hist_bin), 32'd100);
    reset = 1'b1;
    finish = 1'b0;
    hist_ready = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(hist_valid), 32'd0);
    reset = 1'b0;
    clear_model();
    send(129, 9);
    send(130, 9);
    send(131, 9);
    idle();
    start_dump();
    run_dump(0, 1000);
    chk("refill_sum", 32'(sum), 32'd3);
    end_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
